// File: rtl/systema_pio_pkg.sv
// Shared definitions for masters of the systema PIO: register offsets,
// the button-event master state encoding and its bus request bundle.
package systema_pio_pkg;

    localparam logic [1:0]  PIO_DATA     = 2'd0;
    localparam logic [1:0]  PIO_IRQ_MASK = 2'd2;
    localparam logic [1:0]  PIO_EDGE_CAP = 2'd3;

    // Writing ones to the edge-capture register clears those bits.
    localparam logic [31:0] EDGE_CLR_ALL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_EDGE,
        ST_RD_WAIT,
        ST_WR_CLR,
        ST_HOLD,
        ST_WR_CLR2
    } state_e;

    typedef struct packed {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/systema_btn_event_master.sv
// Avalon-MM initiator that arms the button PIO irq, services it in hardware,
// debounces with a hold-off and posts one event word per press burst.
module systema_btn_event_master
    import systema_pio_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] IRQ_MASK = 4'hF,
    parameter int               HOLDOFF  = 50000,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    input  logic             irq,
    output logic [WIDTH-1:0] evt_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_overflow,
    input  logic             ovf_clr,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] evt_data_q, evt_data_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_ovf_q, evt_ovf_d;
    bus_req_t         bus_req;
    logic             post;
    logic             accept;
    logic             unused_rdata;

    assign unused_rdata = ^readdata[31:WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            cap_q       <= '0;
            evt_data_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            evt_data_q  <= evt_data_d;
            evt_valid_q <= evt_valid_d;
            evt_ovf_q   <= evt_ovf_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_IDLE;
            ST_IDLE:    if (irq) state_d = ST_RD_EDGE;
            ST_RD_EDGE: state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_WR_CLR;
            ST_WR_CLR:  state_d = ST_HOLD;
            ST_HOLD:    if (cnt_q == '0) state_d = ST_WR_CLR2;
            ST_WR_CLR2: state_d = ST_IDLE;
            default:    state_d = ST_INIT;
        endcase
    end

    // Bus is forced idle while reset is held, so the slave never sees the INIT write early.
    always_comb begin
        bus_req = '0;
        if (!reset) begin
            case (state_q)
                ST_INIT:    bus_req = '{cs: 1'b1, wr: 1'b1, addr: PIO_IRQ_MASK, wdata: 32'(IRQ_MASK)};
                ST_RD_EDGE: bus_req = '{cs: 1'b1, wr: 1'b0, addr: PIO_EDGE_CAP, wdata: 32'h0};
                ST_WR_CLR,
                ST_WR_CLR2: bus_req = '{cs: 1'b1, wr: 1'b1, addr: PIO_EDGE_CAP, wdata: EDGE_CLR_ALL};
                default:    bus_req = '0;
            endcase
        end
    end

    assign chipselect = bus_req.cs;
    assign write_n    = ~bus_req.wr;
    assign address    = bus_req.addr;
    assign writedata  = bus_req.wdata;
    assign busy       = (state_q != ST_IDLE);

    always_comb begin
        cap_d = cap_q;
        cnt_d = cnt_q;
        if (state_q == ST_RD_WAIT) cap_d = readdata[WIDTH-1:0];
        if (state_q == ST_WR_CLR) begin
            cnt_d = HOLD_LOAD;
        end else if (state_q == ST_HOLD && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // A post into an unaccepted event merges bits instead of dropping them.
    assign post   = (state_q == ST_WR_CLR) && (cap_q != '0);
    assign accept = evt_valid_q && evt_ready;

    always_comb begin
        evt_data_d  = evt_data_q;
        evt_valid_d = evt_valid_q && !accept;
        evt_ovf_d   = evt_ovf_q && !ovf_clr;
        if (post) begin
            if (!evt_valid_q || evt_ready) begin
                evt_data_d  = cap_q;
                evt_valid_d = 1'b1;
            end else begin
                evt_data_d  = evt_data_q | cap_q;
                evt_ovf_d   = 1'b1;
            end
        end
    end

    assign evt_data     = evt_data_q;
    assign evt_valid    = evt_valid_q;
    assign evt_overflow = evt_ovf_q;

endmodule
